wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 1024; watchdog limit in cycles without a bus response, legal 2..65535.
REQ-002 SHALL have parameter HI4, default 0; when 1, channel 4 wins every arbitration in which it requests.
REQ-003 SHALL have parameter TO_W, default 16; watchdog counter width, at least clog2(TO_CYCLES).
REQ-004 SHALL use one clock and a synchronous, active-high reset, as follows.
REQ-005 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req, input, 5 bits: {wbs_cyc4..wbs_cyc0} master requests.
REQ-008 SHALL have port wbm_ack_i, input, 1 bit: slave acknowledge.
REQ-009 SHALL have port wbm_err_i, input, 1 bit: slave error.
REQ-010 SHALL have port wbm_rty_i, input, 1 bit: slave retry.
REQ-011 SHALL have port gnt, output, 5 bits: registered one-hot-or-zero grant to the bus mixer.
REQ-012 SHALL have port busy, output, 1 bit: high while in GRANT.
REQ-013 SHALL have port to_err, output, 1 bit: one-cycle pulse on watchdog expiry.
REQ-014 SHALL have port to_ch, output, 3 bits: index of the last timed-out channel; holds its value until the next expiry.

Function
REQ-015 SHALL implement two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-016 In IDLE with any eligible request, SHALL select a channel by round-robin starting at last+1 modulo 5, enter GRANT, and drive gnt on the next edge (1-cycle latency).
REQ-017 Eligible SHALL mean req[i]=1 and mask[i]=0.
REQ-018 With HI4=1 and channel 4 eligible, SHALL select channel 4 regardless of the round-robin pointer.
REQ-019 On every grant, SHALL load last with the granted index.
REQ-020 In GRANT, SHALL hold gnt unchanged while req[granted]=1; requests on other channels SHALL be ignored.
REQ-021 When req[granted]=0 in GRANT, SHALL return to IDLE with gnt=0 on the next edge.
REQ-022 Consecutive grants SHALL therefore be separated by at least one cycle of gnt=0, with no back-to-back handover.
REQ-023 Watchdog counter SHALL clear on GRANT entry and in any GRANT cycle with wbm_ack_i|wbm_err_i|wbm_rty_i, and otherwise increment in GRANT.
REQ-024 When the counter equals TO_CYCLES-1 without a response, SHALL on the next edge: enter IDLE with gnt=0, pulse to_err for 1 cycle, load to_ch with the index, set mask[index].
REQ-025 SHALL clear mask[i] in any cycle with req[i]=0, so a stuck master is not re-granted until it drops cyc.
REQ-026 A response in the same cycle as the expiry compare SHALL win: counter clears, no timeout.
REQ-027 If req[granted] drops in the same cycle as the expiry compare, the normal release SHALL apply, with no to_err and no mask.
REQ-028 gnt SHALL never have more than one bit set; no X SHALL propagate from an all-zero req.

Reset
REQ-029 While wb_rst_i=1 at an edge, SHALL reset to: state IDLE, gnt=0, busy=0, to_err=0, to_ch=0, counter=0, mask=0, last=4 (so channel 0 is first).
REQ-030 Reset asserted mid-GRANT SHALL drop gnt on that edge with no to_err pulse.

Structure
REQ-031 N_CH=5, the state encoding and the TO_CYCLES default SHALL live in the shared package ssdma_pkg.
REQ-032 Round-robin selection SHALL be one combinational sub-module, arb_rr_pick (inputs: eligible[4:0], last[2:0], hi4; outputs: one-hot pick[4:0], idx[2:0]); all registers stay in wb_arbiter.

Verification
REQ-033 Reset then req=5'b00001 -> gnt=00001 exactly 1 cycle after req is sampled; req drops -> gnt=0 next cycle.
REQ-034 req=5'b11111 held, each master drops after 3 cycles of grant and re-raises -> grant order 0,1,2,3,4,0 with a 1-cycle gnt=0 gap between grants.
REQ-035 HI4=1, req=5'b10010 -> channel 4 is granted first; after it releases and re-requests, channel 4 is granted again before channel 1.
REQ-036 TO_CYCLES=8, ch2 granted, no ack -> gnt=0 and to_err=1 in the 9th grant cycle, to_ch=2; ch2 is not re-granted until req[2] has been low for at least 1 cycle.
REQ-037 TO_CYCLES=8, ack on the 8th grant cycle -> no timeout, counter clears, grant held.
REQ-038 wb_rst_i pulsed during GRANT of ch3 -> gnt=0 and last=4 next cycle; the next grant with all requesting goes to ch0.

Source files
------------

// File: rtl/ssdma_pkg.sv
// Shared constants for the DMA bus arbiter: channel count, FSM encoding,
// watchdog default and the modulo-5 round-robin step helper.
package ssdma_pkg;

    localparam int N_CH          = 5;
    localparam int TO_CYCLES_DEF = 1024;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Pointer value after reset, so that channel 0 is considered first.
    localparam logic [2:0] LAST_RESET = 3'd4;

    // (base + off) mod 5 for base in 0..4 and off in 1..5.
    function automatic logic [2:0] rr_next(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first eligible channel after 'last',
// optionally overridden by channel 4 when hi4 is set.
module arb_rr_pick
    import ssdma_pkg::*;
(
    input  logic [N_CH-1:0] eligible,
    input  logic [2:0]      last,
    input  logic            hi4,
    output logic [N_CH-1:0] pick,
    output logic [2:0]      idx
);

    logic [2:0] cand [N_CH];
    logic       found;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand[gi] = rr_next(last, 3'(gi + 1));
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && eligible[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
        if (hi4 && eligible[4]) begin
            idx = 3'd4;
        end
        pick = found ? (5'b00001 << idx) : 5'b00000;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Five-channel Wishbone arbiter: round-robin grant with a release gap,
// per-grant response watchdog and masking of timed-out masters.
module wb_arbiter
    import ssdma_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter bit HI4       = 1'b0,
    parameter int TO_W      = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N_CH-1:0] req,
    input  logic            wbm_ack_i,
    input  logic            wbm_err_i,
    input  logic            wbm_rty_i,
    output logic [N_CH-1:0] gnt,
    output logic            busy,
    output logic            to_err,
    output logic [2:0]      to_ch
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TO_CYCLES - 1);

    logic [0:0]      state_reg, state_next;
    logic [N_CH-1:0] gnt_reg, gnt_next;
    logic [N_CH-1:0] mask_reg, mask_next, mask_kept;
    logic [TO_W-1:0] cnt_reg, cnt_next;
    logic [2:0]      last_reg, last_next;
    logic [2:0]      cur_reg, cur_next;
    logic [2:0]      to_ch_reg, to_ch_next;
    logic            to_err_reg, to_err_next;

    logic [N_CH-1:0] eligible, pick;
    logic [2:0]      pick_idx;
    logic            resp, expire, req_held;

    assign eligible = req & ~mask_reg;
    assign resp     = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign expire   = (cnt_reg == CNT_LAST);
    assign req_held = req[cur_reg];

    // A mask bit survives only while its master keeps cyc asserted.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_mask
            assign mask_kept[gi] = mask_reg[gi] & req[gi];
        end
    endgenerate

    arb_rr_pick u_pick (
        .eligible (eligible),
        .last     (last_reg),
        .hi4      (HI4),
        .pick     (pick),
        .idx      (pick_idx)
    );

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        cnt_next    = cnt_reg;
        last_next   = last_reg;
        cur_next    = cur_reg;
        to_err_next = 1'b0;
        to_ch_next  = to_ch_reg;
        mask_next   = mask_kept;
        if (state_reg == ST_IDLE) begin
            gnt_next = '0;
            if (|eligible) begin
                state_next = ST_GRANT;
                gnt_next   = pick;
                last_next  = pick_idx;
                cur_next   = pick_idx;
                cnt_next   = '0;
            end
        end else begin
            // Release beats response, response beats expiry.
            if (!req_held) begin
                state_next = ST_IDLE;
                gnt_next   = '0;
                cnt_next   = '0;
            end else if (resp) begin
                cnt_next = '0;
            end else if (expire) begin
                state_next          = ST_IDLE;
                gnt_next            = '0;
                cnt_next            = '0;
                to_err_next         = 1'b1;
                to_ch_next          = cur_reg;
                mask_next[cur_reg]  = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            cnt_reg    <= '0;
            last_reg   <= LAST_RESET;
            cur_reg    <= 3'd0;
            to_err_reg <= 1'b0;
            to_ch_reg  <= 3'd0;
            mask_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            cnt_reg    <= cnt_next;
            last_reg   <= last_next;
            cur_reg    <= cur_next;
            to_err_reg <= to_err_next;
            to_ch_reg  <= to_ch_next;
            mask_reg   <= mask_next;
        end
    end

    assign gnt    = gnt_reg;
    assign busy   = (state_reg == ST_GRANT);
    assign to_err = to_err_reg;
    assign to_ch  = to_ch_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for basic grant/release,
// then hand sequences for rotation, watchdog, reset and channel-4 priority.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ack, err, rty;
    logic [4:0] req0, req1;
    logic [4:0] gnt0, gnt1;
    logic       busy0, busy1, to_err0, to_err1;
    logic [2:0] to_ch0, to_ch1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.TO_CYCLES(8), .HI4(1'b0), .TO_W(16)) dut0 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req      (req0),
        .wbm_ack_i(ack),
        .wbm_err_i(err),
        .wbm_rty_i(rty),
        .gnt      (gnt0),
        .busy     (busy0),
        .to_err   (to_err0),
        .to_ch    (to_ch0)
    );

    wb_arbiter #(.TO_CYCLES(8), .HI4(1'b1), .TO_W(16)) dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req      (req1),
        .wbm_ack_i(ack),
        .wbm_err_i(err),
        .wbm_rty_i(rty),
        .gnt      (gnt1),
        .busy     (busy1),
        .to_err   (to_err1),
        .to_ch    (to_ch1)
    );

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] exp_gnt;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [11];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic chk0(input string name, input logic [4:0] eg, input logic eb, input logic ee);
        check({name, ".gnt"}, {3'b0, gnt0}, {3'b0, eg});
        check({name, ".busy"}, {7'b0, busy0}, {7'b0, eb});
        check({name, ".to_err"}, {7'b0, to_err0}, {7'b0, ee});
    endtask

    initial begin
        rst  = 1'b1;
        req0 = '0;
        req1 = '0;
        ack  = 1'b0;
        err  = 1'b0;
        rty  = 1'b0;

        tbl[0]  = '{1'b1, 5'b00000, 5'b00000, 1'b0};
        tbl[1]  = '{1'b0, 5'b00001, 5'b00001, 1'b1};
        tbl[2]  = '{1'b0, 5'b00001, 5'b00001, 1'b1};
        tbl[3]  = '{1'b0, 5'b00000, 5'b00000, 1'b0};
        tbl[4]  = '{1'b0, 5'b11111, 5'b00010, 1'b1};
        tbl[5]  = '{1'b0, 5'b11111, 5'b00010, 1'b1};
        tbl[6]  = '{1'b0, 5'b11101, 5'b00000, 1'b0};
        tbl[7]  = '{1'b0, 5'b11111, 5'b00100, 1'b1};
        tbl[8]  = '{1'b0, 5'b11011, 5'b00000, 1'b0};
        tbl[9]  = '{1'b0, 5'b00001, 5'b00001, 1'b1};
        tbl[10] = '{1'b0, 5'b00000, 5'b00000, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst  = tbl[i].rst;
            req0 = tbl[i].req;
            step();
            chk0($sformatf("vec%0d", i), tbl[i].exp_gnt, tbl[i].exp_busy, 1'b0);
        end
        check("vec0.to_ch", {5'b0, to_ch0}, 8'd0);

        // Full rotation with 3-cycle tenures and a one-cycle gap between grants.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req0 = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            logic [4:0] oh;
            oh = 5'b00001 << (k % 5);
            for (int c = 0; c < 3; c++) begin
                step();
                chk0($sformatf("rot%0d.c%0d", k, c), oh, 1'b1, 1'b0);
            end
            req0 = 5'b11111 & ~oh;
            step();
            chk0($sformatf("rot%0d.gap", k), 5'b00000, 1'b0, 1'b0);
            req0 = (k < 5) ? 5'b11111 : 5'b00000;
        end
        step();
        chk0("rot.end", 5'b00000, 1'b0, 1'b0);

        // Watchdog expiry on ch2 and masking until cyc drops.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req0 = 5'b00100;
        step();
        chk0("to.g1", 5'b00100, 1'b1, 1'b0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk0($sformatf("to.g%0d", c), 5'b00100, 1'b1, 1'b0);
        end
        step();
        chk0("to.expire", 5'b00000, 1'b0, 1'b1);
        check("to.to_ch", {5'b0, to_ch0}, 8'd2);
        step();
        chk0("to.masked1", 5'b00000, 1'b0, 1'b0);
        check("to.to_ch_hold", {5'b0, to_ch0}, 8'd2);
        step();
        chk0("to.masked2", 5'b00000, 1'b0, 1'b0);
        req0 = 5'b00000;
        step();
        chk0("to.drop", 5'b00000, 1'b0, 1'b0);
        req0 = 5'b00100;
        step();
        chk0("to.regrant", 5'b00100, 1'b1, 1'b0);

        // A response on the expiry-compare cycle wins and clears the counter.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 7; c++) begin
                step();
                check($sformatf("resp%0d.hold%0d", r, c), {3'b0, gnt0}, 8'h04);
            end
            ack = (r == 0);
            err = (r == 1);
            rty = (r == 2);
            step();
            chk0($sformatf("resp%0d.saved", r), 5'b00100, 1'b1, 1'b0);
            ack = 1'b0;
            err = 1'b0;
            rty = 1'b0;
        end
        for (int c = 0; c < 7; c++) begin
            step();
            check($sformatf("resp.fin%0d", c), {3'b0, gnt0}, 8'h04);
        end
        step();
        chk0("resp.expire", 5'b00000, 1'b0, 1'b1);
        req0 = 5'b00000;
        step();

        // Release on the expiry-compare cycle is a normal release.
        req0 = 5'b01000;
        step();
        chk0("rel.g1", 5'b01000, 1'b1, 1'b0);
        repeat (7) step();
        req0 = 5'b00000;
        step();
        chk0("rel.drop", 5'b00000, 1'b0, 1'b0);
        check("rel.to_ch", {5'b0, to_ch0}, 8'd2);
        req0 = 5'b01000;
        step();
        chk0("rel.regrant", 5'b01000, 1'b1, 1'b0);

        // Reset in the middle of ch3's grant.
        req0 = 5'b11111;
        rst  = 1'b1;
        step();
        chk0("rst.mid", 5'b00000, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk0("rst.first", 5'b00001, 1'b1, 1'b0);
        req0 = 5'b00000;
        step();

        // Channel 4 priority on the HI4 instance.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req1 = 5'b10010;
        step();
        check("hi4.g1", {3'b0, gnt1}, 8'h10);
        step();
        check("hi4.hold", {3'b0, gnt1}, 8'h10);
        req1 = 5'b00010;
        step();
        check("hi4.rel", {3'b0, gnt1}, 8'h00);
        req1 = 5'b10010;
        step();
        check("hi4.g2", {3'b0, gnt1}, 8'h10);
        req1 = 5'b00010;
        step();
        check("hi4.rel2", {3'b0, gnt1}, 8'h00);
        step();
        check("hi4.ch1", {3'b0, gnt1}, 8'h02);
        check("hi4.busy", {7'b0, busy1}, 8'h01);
        req1 = 5'b00000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
